icache_refill_ctrl: RTL

Miss-handling controller for the fetch-stage instruction cache. On `instr_miss_f_i` it stalls fetch, issues one burst read to backing memory, and writes the returned words into the victim line. It then pulses `instr_cache_rep_en_o` so the cache commits tag and valid. It sits between the instruction cache and the memory interface, and sequences every line replacement in the fetch path.

---
 rtl/icache_pkg.sv | 19 +
 rtl/icache_refill_ctrl_if.sv | 21 ++
 rtl/refill_beat_counter.sv | 47 ++++
 rtl/icache_refill_ctrl.sv | 119 +++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and constants for the instruction-cache refill path.
package icache_pkg;

    localparam int unsigned ICACHE_LINE_WORDS = 4;
    localparam int unsigned ICACHE_LINE_BYTES = ICACHE_LINE_WORDS * 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } refill_state_t;

    // Mask of the byte-offset bits inside one cache line.
    function automatic int unsigned line_offset_mask(input int unsigned line_bytes);
        return line_bytes - 1;
    endfunction

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Burst-read channel between the refill controller and backing memory.
// Signal suffixes are from the controller's point of view.
interface icache_refill_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req_valid_o;
    logic              mem_req_ready_i;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_rsp_valid_i;
    logic [31:0]       mem_rsp_data_i;

    modport master (
        output mem_req_valid_o, mem_addr_o,
        input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i
    );

    modport slave (
        input  mem_req_valid_o, mem_addr_o,
        output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i
    );
endinterface

// File: rtl/refill_beat_counter.sv
// Tracks the line slot for the current refill beat and flags the final beat.
// The slot index starts anywhere and wraps; a separate beat count drives last_o.
module refill_beat_counter #(
    parameter  int unsigned LINE_WORDS = 4,
    localparam int unsigned IDX_W      = $clog2(LINE_WORDS)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [IDX_W-1:0] start_idx_i,
    input  logic             inc_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             last_o
);
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;

    // Load restarts a refill; each accepted beat advances slot and count together.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        idx_d = idx_q;
        cnt_d = cnt_q;
        if (load_i) begin
            idx_d = start_idx_i;
            cnt_d = '0;
        end else if (inc_i) begin
            idx_d = idx_q + IDX_W'(1);
            cnt_d = cnt_q + IDX_W'(1);
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset_i) begin
            idx_q <= '0;
            cnt_q <= '0;
        end else begin
            idx_q <= idx_d;
            cnt_q <= cnt_d;
        end
    end

    assign idx_o  = idx_q;
    assign last_o = (cnt_q == IDX_W'(LINE_WORDS - 1));

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss handler: stalls fetch, issues one burst read,
// writes the returned words into the victim line, then commits tag/valid.
// Optional build macro ICACHE_CRITICAL_WORD_FIRST_EN starts the burst at the
// missed word instead of the line base.
module icache_refill_ctrl
    import icache_pkg::*;
#(
    parameter  int unsigned LINE_WORDS = ICACHE_LINE_WORDS,
    parameter  int unsigned ADDR_W     = 32,
    localparam int unsigned IDX_W      = $clog2(LINE_WORDS)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [ADDR_W-1:0]         pc_f_i,
    input  logic                      instr_miss_f_i,
    output logic                      stall_f_o,
    icache_refill_ctrl_if.master      mem_if,
    output logic                      fill_we_o,
    output logic [IDX_W-1:0]          fill_word_idx_o,
    output logic [31:0]               fill_data_o,
    output logic [ADDR_W-1:0]         refill_addr_o,
    output logic                      instr_cache_rep_en_o
);
    localparam int unsigned       WORD_BYTES = ICACHE_LINE_BYTES / ICACHE_LINE_WORDS;
    localparam logic [ADDR_W-1:0] OFFS_MASK  = ADDR_W'(line_offset_mask(LINE_WORDS * WORD_BYTES));

    refill_state_t     state_q, state_d;
    logic [ADDR_W-1:0] refill_addr_q, refill_addr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0] line_base;
    logic [ADDR_W-1:0] req_addr;
    logic [IDX_W-1:0]  start_idx;
    logic [IDX_W-1:0]  beat_idx;
    logic              last_beat;
    logic              load_beat;

    assign line_base = pc_f_i & ~OFFS_MASK;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    // Fetch the missed word first; the slot index wraps around the line.
    assign req_addr  = pc_f_i & ~ADDR_W'(3);
    assign start_idx = pc_f_i[2 +: IDX_W];
`else
    // Plain in-order burst from the line base.
    assign req_addr  = line_base;
    assign start_idx = '0;
`endif

    refill_beat_counter #(
        .LINE_WORDS (LINE_WORDS)
    ) u_beat_counter (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .load_i      (load_beat),
        .start_idx_i (start_idx),
        .inc_i       (fill_we_o),
        .idx_o       (beat_idx),
        .last_o      (last_beat)
    );

    // Next-state and state-decoded outputs; addresses are captured only on miss acceptance.
    always_comb begin
        state_d              = state_q;
        refill_addr_d        = refill_addr_q;
        mem_addr_d           = mem_addr_q;
        load_beat            = 1'b0;
        stall_f_o            = 1'b1;
        mem_if.mem_req_valid_o = 1'b0;
        fill_we_o            = 1'b0;
        instr_cache_rep_en_o = 1'b0;

        unique case (state_q)
            IDLE: begin
                stall_f_o = instr_miss_f_i;
                if (instr_miss_f_i) begin
                    state_d       = REQ;
                    refill_addr_d = line_base;
                    mem_addr_d    = req_addr;
                    load_beat     = 1'b1;
                end
            end
            REQ: begin
                mem_if.mem_req_valid_o = 1'b1;
                if (mem_if.mem_req_ready_i) state_d = FILL;
            end
            FILL: begin
                if (mem_if.mem_rsp_valid_i) begin
                    fill_we_o = 1'b1;
                    if (last_beat) state_d = DONE;
                end
            end
            DONE: begin
                instr_cache_rep_en_o = 1'b1;
                state_d              = IDLE;
            end
            default: state_d = IDLE;
        endcase

        fill_word_idx_o = (state_q == FILL) ? beat_idx : '0;
        fill_data_o     = fill_we_o ? mem_if.mem_rsp_data_i : '0;
    end

    // State and latched address registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            refill_addr_q <= '0;
            mem_addr_q    <= '0;
        end else begin
            state_q       <= state_d;
            refill_addr_q <= refill_addr_d;
            mem_addr_q    <= mem_addr_d;
        end
    end

    assign refill_addr_o     = refill_addr_q;
    assign mem_if.mem_addr_o = mem_addr_q;

endmodule
